// File: rtl/eth_helper_pkg.sv
// Shared types and helpers for the Ethernet frame builder: FSM states,
// header field widths and the two-beat header packing.
package eth_helper_pkg;

  localparam int MAC_W  = 48;
  localparam int TYPE_W = 16;
  localparam int SYNC_W = 16;
  localparam int BEAT_W = 64;

  typedef enum logic [2:0] {
    COLLECT,
    DISCARD,
    HDR0,
    HDR1,
    PAYLOAD,
    PAD,
    TRAILER
  } state_t;

  typedef struct packed {
    logic [BEAT_W-1:0] hdr1;
    logic [BEAT_W-1:0] hdr0;
  } hdr_beats_t;

  // Beat 0 carries the whole destination plus the low source half-word.
  function automatic hdr_beats_t pack_header(
    input logic [MAC_W-1:0]  dst,
    input logic [MAC_W-1:0]  src,
    input logic [TYPE_W-1:0] link_type,
    input logic [SYNC_W-1:0] sync
  );
    hdr_beats_t h;
    h.hdr0 = {src[15:0], dst};
    h.hdr1 = {sync, link_type, src[47:16]};
    return h;
  endfunction

endpackage

// File: rtl/eth_payload_fifo.sv
// Payload store for one packet: {keep,data} entries, head word visible
// combinationally on rd_data so the output register can load it directly.
module eth_payload_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge ACLK) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/eth_frame_builder.sv
// Store-and-forward frame builder: collects a payload packet, then emits
// header beats, payload, zero padding and a trailer on M_AXIS.
module eth_frame_builder
  import eth_helper_pkg::*;
#(
  parameter int          FIFO_DEPTH        = 32,
  parameter int          MIN_PAYLOAD_BEATS = 6,
  parameter logic [63:0] TRAILER_WORD      = 64'h1337,
  parameter logic [7:0]  TRAILER_KEEP      = 8'h07,
  parameter int          DATA_WIDTH        = 64
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
  input  logic                    S_AXIS_tvalid,
  input  logic                    S_AXIS_tlast,
  output logic                    S_AXIS_tready,
  input  logic [MAC_W-1:0]        Destination_Addr,
  input  logic [MAC_W-1:0]        Source_Addr,
  input  logic [TYPE_W-1:0]       Link_Type,
  input  logic [SYNC_W-1:0]       SyncWord,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tvalid,
  output logic                    M_AXIS_tlast,
  input  logic                    M_AXIS_tready,
  output logic [31:0]             Frame_Count,
  output logic                    Trunc_Err,
  output logic                    Busy
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int FW         = DATA_WIDTH + KEEP_WIDTH;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic [CNT_W-1:0]        pad_q, pad_d;
  hdr_beats_t              hdr_q, hdr_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0]   m_keep_q, m_keep_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic                    s_ready_q, s_ready_d;
  logic                    trunc_q, trunc_d;
  logic [31:0]             frame_cnt_q, frame_cnt_d;

  logic                    fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [FW-1:0]           fifo_rdata;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        pad_calc;
  logic                    s_acc, m_acc;

  eth_payload_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .wr_en   (fifo_wr),
    .wr_data ({S_AXIS_tkeep, S_AXIS_tdata}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign s_acc    = S_AXIS_tvalid && s_ready_q;
  assign m_acc    = m_valid_q && M_AXIS_tready;
  assign pad_calc = (fifo_count >= CNT_W'(MIN_PAYLOAD_BEATS)) ? '0
                  : CNT_W'(MIN_PAYLOAD_BEATS) - fifo_count;

  // The state names the beat currently held in the output register; the
  // beat for the following state is loaded on the edge that accepts it.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    pad_d       = pad_q;
    hdr_d       = hdr_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    trunc_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    fifo_wr     = 1'b0;
    fifo_rd     = 1'b0;

    case (state_q)
      COLLECT: begin
        if (s_acc) begin
          fifo_wr = !fifo_full;
          n_d     = n_q + 1'b1;
          if (S_AXIS_tlast) begin
            hdr_d   = pack_header(Destination_Addr, Source_Addr, Link_Type, SyncWord);
            state_d = HDR0;
          end else if (n_q == CNT_W'(FIFO_DEPTH - 1)) begin
            hdr_d   = pack_header(Destination_Addr, Source_Addr, Link_Type, SyncWord);
            trunc_d = 1'b1;
            state_d = DISCARD;
          end
        end
      end

      DISCARD: begin
        if (s_acc && S_AXIS_tlast) begin
          state_d = HDR0;
        end
      end

      HDR0: begin
        if (!m_valid_q) begin
          m_data_d  = hdr_q.hdr0;
          m_keep_d  = '1;
          m_last_d  = 1'b0;
          m_valid_d = 1'b1;
          pad_d     = pad_calc;
        end else if (m_acc) begin
          m_data_d = hdr_q.hdr1;
          state_d  = HDR1;
        end
      end

      HDR1: begin
        if (m_acc) begin
          m_data_d = fifo_rdata[DATA_WIDTH-1:0];
          m_keep_d = fifo_rdata[FW-1:DATA_WIDTH];
          fifo_rd  = 1'b1;
          state_d  = PAYLOAD;
        end
      end

      PAYLOAD, PAD: begin
        if (m_acc) begin
          if (state_q == PAYLOAD && !fifo_empty) begin
            m_data_d = fifo_rdata[DATA_WIDTH-1:0];
            m_keep_d = fifo_rdata[FW-1:DATA_WIDTH];
            fifo_rd  = 1'b1;
          end else if (pad_q != '0) begin
            m_data_d = '0;
            m_keep_d = '1;
            pad_d    = pad_q - 1'b1;
            state_d  = PAD;
          end else begin
            m_data_d = TRAILER_WORD;
            m_keep_d = TRAILER_KEEP;
            m_last_d = 1'b1;
            state_d  = TRAILER;
          end
        end
      end

      TRAILER: begin
        if (m_acc) begin
          m_data_d    = '0;
          m_keep_d    = '0;
          m_last_d    = 1'b0;
          m_valid_d   = 1'b0;
          n_d         = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = COLLECT;
        end
      end

      default: state_d = COLLECT;
    endcase

    s_ready_d = (state_d == COLLECT) || (state_d == DISCARD);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= COLLECT;
      n_q         <= '0;
      pad_q       <= '0;
      hdr_q       <= '0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      s_ready_q   <= 1'b0;
      trunc_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      pad_q       <= pad_d;
      hdr_q       <= hdr_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      s_ready_q   <= s_ready_d;
      trunc_q     <= trunc_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign S_AXIS_tready = s_ready_q;
  assign M_AXIS_tdata  = m_data_q;
  assign M_AXIS_tkeep  = m_keep_q;
  assign M_AXIS_tvalid = m_valid_q;
  assign M_AXIS_tlast  = m_last_q;
  assign Frame_Count   = frame_cnt_q;
  assign Trunc_Err     = trunc_q;
  assign Busy          = (state_q != COLLECT);

endmodule

// File: tb/tb_eth_frame_builder.sv
// Directed bench for eth_frame_builder: expected beats are queued when a
// packet is driven and compared as the DUT emits them.
module tb_eth_frame_builder;

  localparam int DEPTH = 32;
  localparam int MINP  = 6;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [63:0] S_AXIS_tdata;
  logic [7:0]  S_AXIS_tkeep;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tlast;
  logic        S_AXIS_tready;
  logic [47:0] Destination_Addr;
  logic [47:0] Source_Addr;
  logic [15:0] Link_Type;
  logic [15:0] SyncWord;
  logic [63:0] M_AXIS_tdata;
  logic [7:0]  M_AXIS_tkeep;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tlast;
  logic        M_AXIS_tready = 1'b1;
  logic [31:0] Frame_Count;
  logic        Trunc_Err;
  logic        Busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [72:0] exp_q[$];

  // monitor state
  int          frame_beats = 0;
  int          frames_seen = 0;
  int          first_valid_cyc = 0;
  int          last_beat_cyc = 0;
  int          trunc_pulses = 0;
  bit          frame_active = 0;
  bit          stalled_prev = 0;
  logic [73:0] held;
  logic [72:0] exp_beat;
  logic [63:0] first_data;

  // stimulus side
  bit          bp_en = 0;
  int          send_stalls;
  int          trunc_beat;
  int          tlast_cyc;
  int          trunc_before;

  eth_frame_builder #(
    .FIFO_DEPTH        (DEPTH),
    .MIN_PAYLOAD_BEATS (MINP),
    .TRAILER_WORD      (64'h1337),
    .TRAILER_KEEP      (8'h07),
    .DATA_WIDTH        (64)
  ) dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .S_AXIS_tdata     (S_AXIS_tdata),
    .S_AXIS_tkeep     (S_AXIS_tkeep),
    .S_AXIS_tvalid    (S_AXIS_tvalid),
    .S_AXIS_tlast     (S_AXIS_tlast),
    .S_AXIS_tready    (S_AXIS_tready),
    .Destination_Addr (Destination_Addr),
    .Source_Addr      (Source_Addr),
    .Link_Type        (Link_Type),
    .SyncWord         (SyncWord),
    .M_AXIS_tdata     (M_AXIS_tdata),
    .M_AXIS_tkeep     (M_AXIS_tkeep),
    .M_AXIS_tvalid    (M_AXIS_tvalid),
    .M_AXIS_tlast     (M_AXIS_tlast),
    .M_AXIS_tready    (M_AXIS_tready),
    .Frame_Count      (Frame_Count),
    .Trunc_Err        (Trunc_Err),
    .Busy             (Busy)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  always @(posedge ACLK) begin
    #1;
    M_AXIS_tready = bp_en ? 1'($urandom & 1) : 1'b1;
  end

  // Output monitor: sampled on the falling edge, between active edges.
  always @(negedge ACLK) begin
    if (ARESET) begin
      frame_active = 0;
      stalled_prev = 0;
    end else begin
      if (Trunc_Err) trunc_pulses++;
      if (stalled_prev) begin
        checks++;
        assert ({M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata} === held)
        else begin
          errors++;
          $error("FAIL stall_hold: observed %h expected %h",
                 {M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata}, held);
        end
      end
      stalled_prev = 0;
      if (M_AXIS_tvalid) begin
        if (!frame_active) begin
          frame_active    = 1;
          frame_beats     = 0;
          first_valid_cyc = cyc;
          first_data      = M_AXIS_tdata;
        end
        if (M_AXIS_tready) begin
          exp_beat = (exp_q.size() != 0) ? exp_q.pop_front() : 73'h1_FF_FFFF_FFFF_FFFF_FFFF;
          checks++;
          assert ({M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata} === exp_beat)
          else begin
            errors++;
            $error("FAIL beat%0d: observed %h expected %h", frame_beats,
                   {M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata}, exp_beat);
          end
          frame_beats++;
          last_beat_cyc = cyc;
          if (M_AXIS_tlast) begin
            frame_active = 0;
            frames_seen++;
            $display("frame %0d: %0d beats, hdr0 %h, cycles %0d..%0d",
                     frames_seen, frame_beats, first_data, first_valid_cyc, last_beat_cyc);
          end
        end else begin
          stalled_prev = 1;
          held = {M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tkeep, M_AXIS_tdata};
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr0(input logic [47:0] d, input logic [47:0] s);
    return {s[15:0], d};
  endfunction

  function automatic logic [63:0] mk_hdr1(input logic [47:0] s, input logic [15:0] t,
                                          input logic [15:0] y);
    return {y, t, s[47:16]};
  endfunction

  task automatic push_frame(input logic [63:0] h0, input logic [63:0] h1, input int n,
                            input logic [63:0] base, input logic [7:0] lk);
    int stored;
    stored = (n > DEPTH) ? DEPTH : n;
    exp_q.push_back({1'b0, 8'hFF, h0});
    exp_q.push_back({1'b0, 8'hFF, h1});
    for (int i = 0; i < stored; i++)
      exp_q.push_back({1'b0, (i == n - 1) ? lk : 8'hFF, base + 64'(i)});
    for (int i = stored; i < MINP; i++)
      exp_q.push_back({1'b0, 8'hFF, 64'h0});
    exp_q.push_back({1'b1, 8'h07, 64'h1337});
  endtask

  task automatic send_packet(input int n, input logic [63:0] base, input logic [7:0] lk);
    int waited;
    send_stalls = 0;
    trunc_beat  = 0;
    for (int i = 0; i < n; i++) begin
      S_AXIS_tdata  = base + 64'(i);
      S_AXIS_tkeep  = (i == n - 1) ? lk : 8'hFF;
      S_AXIS_tlast  = (i == n - 1);
      S_AXIS_tvalid = 1'b1;
      waited = 0;
      @(negedge ACLK);
      while (!S_AXIS_tready && waited < 200) begin
        waited++;
        @(negedge ACLK);
      end
      send_stalls += waited;
      if (waited >= 200) begin
        chk("s_ready_timeout", 128'(waited), 128'(0));
        break;
      end
      @(posedge ACLK);
      #1;
      if (Trunc_Err) trunc_beat = i + 1;
      if (i == n - 1) tlast_cyc = cyc;
    end
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || M_AXIS_tvalid) && k < 3000) begin
      @(posedge ACLK);
      k++;
    end
    #1;
    chk({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
    chk({tag, "_in_time"}, 128'(k < 3000), 128'(1));
  endtask

  task automatic wait_beats(input int nb);
    int k;
    k = 0;
    while (frame_beats < nb && k < 500) begin
      @(posedge ACLK);
      k++;
    end
    chk("wait_beats_in_time", 128'(k < 500), 128'(1));
  endtask

  initial begin
    S_AXIS_tdata     = '0;
    S_AXIS_tkeep     = '0;
    S_AXIS_tvalid    = 1'b0;
    S_AXIS_tlast     = 1'b0;
    Destination_Addr = 48'h1122_3344_5566;
    Source_Addr      = 48'hA1A2_A3A4_A5A6;
    Link_Type        = 16'h0800;
    SyncWord         = 16'h55D5;

    // reset state
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_tvalid", 128'(M_AXIS_tvalid), 128'(0));
    chk("rst_tdata", 128'(M_AXIS_tdata), 128'(0));
    chk("rst_tkeep", 128'(M_AXIS_tkeep), 128'(0));
    chk("rst_tlast", 128'(M_AXIS_tlast), 128'(0));
    chk("rst_trunc", 128'(Trunc_Err), 128'(0));
    chk("rst_busy", 128'(Busy), 128'(0));
    chk("rst_frame_count", 128'(Frame_Count), 128'(0));
    chk("rst_s_ready", 128'(S_AXIS_tready), 128'(0));
    ARESET = 1'b0;
    #1 chk("s_ready_before_edge", 128'(S_AXIS_tready), 128'(0));
    @(posedge ACLK);
    #1 chk("s_ready_after_release", 128'(S_AXIS_tready), 128'(1));

    // 1: single beat, literal header beats
    push_frame(64'hA5A6_1122_3344_5566, 64'h55D5_0800_A1A2_A3A4, 1, 64'hAABB, 8'hFF);
    send_packet(1, 64'hAABB, 8'hFF);
    chk("t1_busy", 128'(Busy), 128'(1));
    wait_idle("t1");
    chk("t1_beats", 128'(frame_beats), 128'(9));
    chk("t1_frame_count", 128'(Frame_Count), 128'(1));

    // 2: 8 beats, last keep 0F, no pad, contiguous output
    push_frame(mk_hdr0(Destination_Addr, Source_Addr),
               mk_hdr1(Source_Addr, Link_Type, SyncWord), 8, 64'hC0DE_0000_0000_0100, 8'h0F);
    send_packet(8, 64'hC0DE_0000_0000_0100, 8'h0F);
    wait_idle("t2");
    chk("t2_beats", 128'(frame_beats), 128'(11));
    chk("t2_latency", 128'(first_valid_cyc - tlast_cyc), 128'(1));
    chk("t2_contiguous", 128'(last_beat_cyc - first_valid_cyc), 128'(10));
    chk("t2_frame_count", 128'(Frame_Count), 128'(2));

    // 3: random backpressure on a 3-beat payload
    bp_en = 1;
    push_frame(mk_hdr0(Destination_Addr, Source_Addr),
               mk_hdr1(Source_Addr, Link_Type, SyncWord), 3, 64'h3333_0000_0000_0000, 8'h3F);
    send_packet(3, 64'h3333_0000_0000_0000, 8'h3F);
    wait_idle("t3");
    bp_en = 0;
    chk("t3_beats", 128'(frame_beats), 128'(9));
    chk("t3_frame_count", 128'(Frame_Count), 128'(3));

    // 4: 40-beat input truncated to FIFO_DEPTH
    trunc_before = trunc_pulses;
    push_frame(mk_hdr0(Destination_Addr, Source_Addr),
               mk_hdr1(Source_Addr, Link_Type, SyncWord), 40, 64'h4040_0000_0000_0000, 8'h01);
    send_packet(40, 64'h4040_0000_0000_0000, 8'h01);
    chk("t4_trunc_beat", 128'(trunc_beat), 128'(DEPTH));
    chk("t4_no_input_stalls", 128'(send_stalls), 128'(0));
    wait_idle("t4");
    chk("t4_trunc_pulses", 128'(trunc_pulses - trunc_before), 128'(1));
    chk("t4_beats", 128'(frame_beats), 128'(DEPTH + 3));
    chk("t4_frame_count", 128'(Frame_Count), 128'(4));

    // 5: exactly FIFO_DEPTH beats with tlast is not a truncation
    trunc_before = trunc_pulses;
    push_frame(mk_hdr0(Destination_Addr, Source_Addr),
               mk_hdr1(Source_Addr, Link_Type, SyncWord), DEPTH, 64'h5050_0000_0000_0000, 8'hFF);
    send_packet(DEPTH, 64'h5050_0000_0000_0000, 8'hFF);
    wait_idle("t5");
    chk("t5_no_trunc", 128'(trunc_pulses - trunc_before), 128'(0));
    chk("t5_frame_count", 128'(Frame_Count), 128'(5));

    // 6: reset while padding, then a clean frame
    push_frame(mk_hdr0(Destination_Addr, Source_Addr),
               mk_hdr1(Source_Addr, Link_Type, SyncWord), 1, 64'h6666, 8'hFF);
    send_packet(1, 64'h6666, 8'hFF);
    wait_beats(4);
    #2;
    ARESET = 1'b1;
    #1;
    chk("t6_tvalid_async", 128'(M_AXIS_tvalid), 128'(0));
    chk("t6_no_frame_counted", 128'(Frame_Count), 128'(0));
    chk("t6_busy", 128'(Busy), 128'(0));
    exp_q.delete();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    push_frame(mk_hdr0(Destination_Addr, Source_Addr),
               mk_hdr1(Source_Addr, Link_Type, SyncWord), 1, 64'h7777, 8'hFF);
    send_packet(1, 64'h7777, 8'hFF);
    wait_idle("t6");
    chk("t6_beats", 128'(frame_beats), 128'(9));
    chk("t6_frame_count", 128'(Frame_Count), 128'(1));

    // 7: header inputs change mid-frame
    push_frame(mk_hdr0(Destination_Addr, Source_Addr),
               mk_hdr1(Source_Addr, Link_Type, SyncWord), 8, 64'h8888_0000_0000_0000, 8'hFF);
    send_packet(8, 64'h8888_0000_0000_0000, 8'hFF);
    wait_beats(3);
    Destination_Addr = 48'h0A0B_0C0D_0E0F;
    Source_Addr      = 48'h1020_3040_5060;
    Link_Type        = 16'h86DD;
    SyncWord         = 16'hAA55;
    wait_idle("t7a");
    push_frame(64'h5060_0A0B_0C0D_0E0F, 64'hAA55_86DD_1020_3040, 2, 64'h9999_0000_0000_0000, 8'h7F);
    send_packet(2, 64'h9999_0000_0000_0000, 8'h7F);
    wait_idle("t7b");
    chk("t7_beats", 128'(frame_beats), 128'(9));
    chk("t7_frame_count", 128'(Frame_Count), 128'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
